// File: rtl/bullet_pool_ctrl.sv
// Bullet pool controller: a fixed set of bullet slots, round-robin spawn arbitration
// across requesters, and a one-slot-per-cycle motion/retire pass on each frame edge.
module bullet_pool_ctrl #(
    parameter int NB    = 8,
    parameter int NREQ  = 2,
    parameter int X_MAX = 639,
    parameter int Y_MAX = 479
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 frame_clk,
    input  logic [NREQ-1:0]      spawn_req,
    input  logic [NREQ*11-1:0]   spawn_x,
    input  logic [NREQ*11-1:0]   spawn_y,
    input  logic [NREQ*8-1:0]    spawn_vx,
    input  logic [NREQ*8-1:0]    spawn_vy,
    output logic [NREQ-1:0]      spawn_ack,
    output logic [NB*11-1:0]     BulletX,
    output logic [NB*11-1:0]     BulletY,
    output logic [NB-1:0]        bullet_active,
    output logic                 pool_full,
    output logic                 busy,
    output logic                 frame_overrun
);

    localparam int IW = $clog2(NB);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_UPDATE = 1'b1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
    localparam logic [PW-1:0] LAST_REQ = PW'(NREQ - 1);
    localparam logic [11:0] X_LIM = 12'(X_MAX);
    localparam logic [11:0] Y_LIM = 12'(Y_MAX);

    logic [0:0]      state_r;
    logic [IW-1:0]   idx_r;
    logic [PW-1:0]   rr_ptr_r;
    logic            frame_q_r;
    logic            overrun_r;
    logic [NB-1:0]   act_r;
    logic [10:0]     x_r  [NB];
    logic [10:0]     y_r  [NB];
    logic [7:0]      vx_r [NB];
    logic [7:0]      vy_r [NB];

    logic            fe_s;
    logic            full_s;
    logic [IW-1:0]   free_idx_s;
    logic [2*NREQ-1:0] rot_s;
    logic [PW:0]     offset_s;
    logic [PW:0]     sum_s;
    logic            grant_found_s;
    logic [PW-1:0]   grant_idx_s;
    logic [PW-1:0]   rr_next_s;
    logic            spawn_en_s;
    logic [10:0]     sel_x_s;
    logic [10:0]     sel_y_s;
    logic [7:0]      sel_vx_s;
    logic [7:0]      sel_vy_s;
    logic [11:0]     nx_s;
    logic [11:0]     ny_s;
    logic            exit_s;

    assign fe_s      = frame_clk & ~frame_q_r;
    assign full_s    = &act_r;
    assign pool_full = full_s;
    assign busy      = (state_r == ST_UPDATE);
    assign frame_overrun = overrun_r;
    assign bullet_active = act_r;

    // Lowest-index inactive slot (scan from the top so the lowest hit wins)
    always_comb begin
        free_idx_s = {IW{1'b0}};
        for (int i = NB - 1; i >= 0; i--) begin
            free_idx_s = act_r[i] ? free_idx_s : IW'(i);
        end
    end

    // Round-robin grant: rotate requests so rr_ptr lands at bit 0, take the first set bit
    always_comb begin
        rot_s         = {spawn_req, spawn_req} >> rr_ptr_r;
        offset_s      = {(PW+1){1'b0}};
        grant_found_s = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            offset_s      = rot_s[k] ? (PW+1)'(k) : offset_s;
            grant_found_s = rot_s[k] | grant_found_s;
        end
        sum_s = {1'b0, rr_ptr_r} + offset_s;
        if (sum_s >= (PW+1)'(NREQ)) begin
            grant_idx_s = PW'(sum_s - (PW+1)'(NREQ));
        end else begin
            grant_idx_s = PW'(sum_s);
        end
        rr_next_s  = (grant_idx_s == LAST_REQ) ? {PW{1'b0}} : grant_idx_s + PW'(1);
        spawn_en_s = Reset_n & (state_r == ST_IDLE) & ~fe_s & grant_found_s & ~full_s;
    end

    // Granted requester's spawn data and the one-hot acknowledge
    always_comb begin
        sel_x_s   = 11'd0;
        sel_y_s   = 11'd0;
        sel_vx_s  = 8'd0;
        sel_vy_s  = 8'd0;
        spawn_ack = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            sel_x_s      = (grant_idx_s == PW'(i)) ? spawn_x[11*i +: 11] : sel_x_s;
            sel_y_s      = (grant_idx_s == PW'(i)) ? spawn_y[11*i +: 11] : sel_y_s;
            sel_vx_s     = (grant_idx_s == PW'(i)) ? spawn_vx[8*i +: 8]  : sel_vx_s;
            sel_vy_s     = (grant_idx_s == PW'(i)) ? spawn_vy[8*i +: 8]  : sel_vy_s;
            spawn_ack[i] = spawn_en_s & (grant_idx_s == PW'(i));
        end
    end

    // Next position of the slot under update; a negative result has bit 11 set
    always_comb begin
        nx_s   = {1'b0, x_r[idx_r]} + {{4{vx_r[idx_r][7]}}, vx_r[idx_r]};
        ny_s   = {1'b0, y_r[idx_r]} + {{4{vy_r[idx_r][7]}}, vy_r[idx_r]};
        exit_s = nx_s[11] | (nx_s > X_LIM) | ny_s[11] | (ny_s > Y_LIM);
    end

    // Flatten slot registers onto the renderer/collision buses
    always_comb begin
        BulletX = {(NB*11){1'b0}};
        BulletY = {(NB*11){1'b0}};
        for (int i = 0; i < NB; i++) begin
            BulletX[11*i +: 11] = x_r[i];
            BulletY[11*i +: 11] = y_r[i];
        end
    end

    // Pass sequencing, slot motion/retire and spawn writes
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r   <= ST_IDLE;
            idx_r     <= {IW{1'b0}};
            rr_ptr_r  <= {PW{1'b0}};
            frame_q_r <= 1'b0;
            overrun_r <= 1'b0;
            act_r     <= {NB{1'b0}};
            for (int i = 0; i < NB; i++) begin
                x_r[i]  <= 11'd0;
                y_r[i]  <= 11'd0;
                vx_r[i] <= 8'd0;
                vy_r[i] <= 8'd0;
            end
        end else begin
            frame_q_r <= frame_clk;
            overrun_r <= (state_r == ST_UPDATE) & fe_s;
            case (state_r)
                ST_IDLE: begin
                    if (fe_s) begin
                        state_r <= ST_UPDATE;
                        idx_r   <= {IW{1'b0}};
                    end else if (spawn_en_s) begin
                        act_r[free_idx_s] <= 1'b1;
                        x_r[free_idx_s]   <= sel_x_s;
                        y_r[free_idx_s]   <= sel_y_s;
                        vx_r[free_idx_s]  <= sel_vx_s;
                        vy_r[free_idx_s]  <= sel_vy_s;
                        rr_ptr_r          <= rr_next_s;
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                ST_UPDATE: begin
                    // A retired slot keeps its last on-screen coordinates
                    if (act_r[idx_r]) begin
                        if (exit_s) begin
                            act_r[idx_r] <= 1'b0;
                        end else begin
                            x_r[idx_r] <= nx_s[10:0];
                            y_r[idx_r] <= ny_s[10:0];
                        end
                    end else begin
                        act_r[idx_r] <= 1'b0;
                    end
                    if (idx_r == LAST_IDX) begin
                        state_r <= ST_IDLE;
                        idx_r   <= {IW{1'b0}};
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    idx_r   <= {IW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: doc/bullet_pool_ctrl.md
Name: bullet_pool_ctrl

Overview:
- Owns a fixed pool of NB bullet slots: position, velocity and active flag per slot.
- Accepts spawn requests from NREQ requesters (player, enemy units), shared by a round-robin arbiter.
- On each frame tick, sequentially advances every active bullet by its velocity and retires any that leave the screen.
- Its packed X/Y/active outputs drive the per-slot bullet renderer instances and the collision logic.

Parameters:
- NB, 8, number of bullet slots (2..16)
- NREQ, 2, number of spawn requesters (1..4)
- X_MAX, 639, largest on-screen X coordinate
- Y_MAX, 479, largest on-screen Y coordinate

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  synchronous reset, active low
- frame_clk  in  1  frame tick (vsync-derived), synchronous to Clk; rising edge starts an update pass
- spawn_req  in  NREQ  per-requester spawn request; held high until acked
- spawn_x  in  NREQ*11  spawn X per requester (requester i at bits [11i+10:11i])
- spawn_y  in  NREQ*11  spawn Y per requester
- spawn_vx  in  NREQ*8  signed X velocity per requester, pixels/frame
- spawn_vy  in  NREQ*8  signed Y velocity per requester
- spawn_ack  out  NREQ  one-hot, combinational; high in the cycle the request is accepted
- BulletX  out  NB*11  per-slot X, registered
- BulletY  out  NB*11  per-slot Y, registered
- bullet_active  out  NB  per-slot valid, registered
- pool_full  out  1  all slots active (combinational from bullet_active)
- busy  out  1  update pass in progress
- frame_overrun  out  1  one-cycle pulse when a frame edge arrives while busy

Behaviour:
- Reset (Reset_n low at a Clk edge):
  - bullet_active, BulletX, BulletY and stored velocities all cleared to 0.
  - FSM goes to IDLE; slot index 0; round-robin pointer 0.
  - Edge-detect register goes to 0; frame_overrun goes to 0.
  - Reset during UPDATE aborts the pass immediately.
- Frame edge: fe = frame_clk & ~frame_clk_q. frame_clk_q is registered every cycle.
- FSM states: IDLE, UPDATE.
  - IDLE and fe: go to UPDATE, idx <= 0, busy=1 from the next cycle.
  - UPDATE: process slot idx each cycle. If idx==NB-1, return to IDLE; otherwise idx+1.
  - A pass takes exactly NB cycles. busy is high for exactly those NB cycles.
  - UPDATE and fe: fe is ignored; frame_overrun pulses for 1 cycle.
- Slot update, in 12-bit signed arithmetic:
  - nx = {0,X} + sext(vx); ny = {0,Y} + sext(vy).
  - If nx<0, nx>X_MAX, ny<0 or ny>Y_MAX: clear active. X and Y hold their last values.
  - Otherwise X<=nx[10:0], Y<=ny[10:0].
  - Inactive slots are untouched.
- Spawn arbitration:
  - Evaluated only in IDLE on a cycle with fe=0. No acks in UPDATE or on the fe cycle.
  - Grant goes to the first requesting index at or after rr_ptr, wrapping modulo NREQ.
  - The grant is issued only if a free slot exists.
  - The granted requester's data is written to the lowest-index inactive slot at the next edge: active<=1, X, Y, vx, vy.
  - spawn_ack[g]=1 in that same cycle; rr_ptr <= (g+1) mod NREQ.
  - At most one spawn per cycle. The requester must deassert or present a new request after seeing ack.
- pool_full=1: no grant, no ack. Requests stay pending (not dropped) until a slot frees in a later pass.
- Spawn coordinates are not checked at spawn time. An out-of-range spawn is retired on the next pass that visits it.
- A slot retired in a pass is reusable from the first IDLE cycle after the pass.

Test Plan:
- Reset then idle: Reset_n=0 for 2 cycles, release → bullet_active=0, busy=0, spawn_ack=0, pool_full=0.
- Single spawn + motion: req0 with x=100, y=200, vx=+5, vy=-3 → ack0 in same cycle, slot0 active. After fe and NB=8 cycles: X=105, Y=197. busy high for exactly 8 cycles.
- Round-robin: req0 and req1 held continuously in IDLE → acks alternate 0,1,0,1, filling slots 0..3 in order.
- Full pool: 8 spawns, then req1 held → pool_full=1, no ack. Slot 2 exits at x=2, vx=-4 on the next pass → req1 acked on the first IDLE cycle after it, into slot 2.
- Boundary: x=635, vx=+4 → X=639, stays active. Next pass: 643 → active cleared, X stays 639. Also y=0, vy=-1 → retired.
- Overrun/reset: fe during UPDATE → frame_overrun 1-cycle pulse, pass length unchanged. Reset_n=0 at idx=3 → all outputs 0, FSM IDLE next cycle.
